heartbeat_gen: RTL

- Driver end of the watchdog observe/match interface. It periodically drives a heartbeat pulse onto the line a remote watchdog observes, then checks that the watchdog's match-event acknowledge comes back in time.
- A prescaler turns the 100 MHz clock into ticks. Pulse period, pulse width and acknowledge window are counted in ticks.
- Consecutive missed acknowledges are counted. Reaching MAX_MISS latches a fault that stays set until software clears it.

---
 rtl/heartbeat_gen_pkg.sv | 26 ++
 rtl/dff.sv | 17 +
 rtl/heartbeat_gen_tick_prescaler.sv | 31 +++
 rtl/heartbeat_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/heartbeat_gen_pkg.sv
// Shared definitions for the heartbeat generator: FSM state encoding and
// miss-counter width.
package heartbeat_gen_pkg;

  localparam int MISS_CNT_W = 4;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PULSE    = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK = 3'd2;
  localparam logic [2:0] ST_GAP      = 3'd3;
  localparam logic [2:0] ST_FAULT    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_PULSE    = ST_PULSE,
    S_WAIT_ACK = ST_WAIT_ACK,
    S_GAP      = ST_GAP,
    S_FAULT    = ST_FAULT
  } hbState_e;

  // The prescaler only runs while a heartbeat cycle is in progress.
  function automatic logic isBusy(input hbState_e s);
    return (s == S_PULSE) || (s == S_WAIT_ACK) || (s == S_GAP);
  endfunction

endpackage

// File: rtl/dff.sv
// Plain resettable register cell, used here to build the ack synchroniser.
module dff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_q <= RST_VAL;
    else          o_q <= i_d;
  end

endmodule

// File: rtl/heartbeat_gen_tick_prescaler.sv
// Clock-to-tick divider: one-cycle tick every CLK_DIV cycles while running,
// with a synchronous clear that realigns the tick phase.
module tick_prescaler #(
  parameter int CLK_DIV = 100000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  logic i_clear,
  output logic o_tick
);

  localparam int               CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear)    cnt_d = '0;
    else if (i_run) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_tick = i_run && (cnt_q == LAST);

endmodule

// File: rtl/heartbeat_gen.sv
// Heartbeat driver: emits periodic pulses toward a remote watchdog, checks the
// acknowledge window and latches a sticky fault after MAX_MISS misses in a row.
module heartbeat_gen
  import heartbeat_gen_pkg::*;
#(
  parameter int CLK_DIV      = 100000,
  parameter int PERIOD_TICKS = 500,
  parameter int PULSE_TICKS  = 10,
  parameter int ACK_TICKS    = 100,
  parameter int MAX_MISS     = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_active_lvl,
  input  logic                  i_ack,
  input  logic                  i_clr,
  output logic                  o_hb,
  output logic                  o_pulse_start,
  output logic                  o_miss,
  output logic [MISS_CNT_W-1:0] o_miss_cnt,
  output logic                  o_fault,
  output logic                  o_busy
);

  localparam int                    TICK_W     = $clog2(PERIOD_TICKS + 1);
  localparam logic [TICK_W:0]       PULSE_LIM  = (TICK_W + 1)'(PULSE_TICKS);
  localparam logic [TICK_W:0]       ACK_LIM    = (TICK_W + 1)'(ACK_TICKS);
  localparam logic [TICK_W:0]       PERIOD_LIM = (TICK_W + 1)'(PERIOD_TICKS);
  localparam logic [MISS_CNT_W-1:0] MAX_MISS_V = MISS_CNT_W'(MAX_MISS);

  hbState_e              state_q, state_d;
  logic                  hb_q, hb_d;
  logic                  lvl_q, lvl_d;
  logic                  pulseStart_q, pulseStart_d;
  logic                  miss_q, miss_d;
  logic [MISS_CNT_W-1:0] missCnt_q, missCnt_d;
  logic                  fault_q, fault_d;
  logic                  busy_q, busy_d;
  logic [TICK_W-1:0]     phaseCnt_q, phaseCnt_d;
  logic [TICK_W-1:0]     periodCnt_q, periodCnt_d;

  logic                  ackMeta, ackSync;
  logic                  tick, preClear, startPulse, abort;
  logic [TICK_W:0]       phaseInc, periodInc;
  logic [MISS_CNT_W-1:0] missInc;

  dff u_ackSync1 (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_ack),   .o_q(ackMeta));
  dff u_ackSync2 (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(ackMeta), .o_q(ackSync));

  tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_run  (isBusy(state_q)),
    .i_clear(preClear),
    .o_tick (tick)
  );

  assign phaseInc  = {1'b0, phaseCnt_q}  + (TICK_W + 1)'(1);
  assign periodInc = {1'b0, periodCnt_q} + (TICK_W + 1)'(1);
  assign missInc   = (missCnt_q == '1) ? missCnt_q : missCnt_q + MISS_CNT_W'(1);

  // Phase counter times pulse width and ack window; period counter runs from pulse start.
  always_comb begin
    state_d      = state_q;
    hb_d         = hb_q;
    lvl_d        = lvl_q;
    pulseStart_d = 1'b0;
    miss_d       = 1'b0;
    missCnt_d    = missCnt_q;
    fault_d      = fault_q;
    phaseCnt_d   = phaseCnt_q;
    periodCnt_d  = periodCnt_q;
    preClear     = 1'b0;
    startPulse   = 1'b0;
    abort        = 1'b0;

    if (tick) begin
      phaseCnt_d  = phaseInc[TICK_W-1:0];
      periodCnt_d = periodInc[TICK_W-1:0];
    end

    case (state_q)
      S_IDLE: begin
        if (i_en && !fault_q) startPulse = 1'b1;
      end
      S_PULSE: begin
        if (!i_en) abort = 1'b1;
        else if (tick && (phaseInc >= PULSE_LIM)) begin
          state_d    = S_WAIT_ACK;
          hb_d       = ~lvl_q;
          phaseCnt_d = '0;
        end
      end
      S_WAIT_ACK: begin
        if (!i_en) abort = 1'b1;
        else if (ackSync) begin
          missCnt_d = '0;
          state_d   = S_GAP;
        end else if (tick && (phaseInc >= ACK_LIM)) begin
          miss_d    = 1'b1;
          missCnt_d = i_clr ? '0 : missInc;
          if (missCnt_d == MAX_MISS_V) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (!i_en) abort = 1'b1;
        else if (tick && (periodInc >= PERIOD_LIM)) startPulse = 1'b1;
      end
      S_FAULT: begin
        if (i_clr) begin
          fault_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (i_clr) missCnt_d = '0;

    if (abort) begin
      state_d = S_IDLE;
      hb_d    = ~lvl_q;
    end

    if (startPulse) begin
      state_d      = S_PULSE;
      lvl_d        = i_active_lvl;
      hb_d         = i_active_lvl;
      pulseStart_d = 1'b1;
      preClear     = 1'b1;
      phaseCnt_d   = '0;
      periodCnt_d  = '0;
    end

    busy_d = isBusy(state_d);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      hb_q         <= 1'b1;
      lvl_q        <= 1'b0;
      pulseStart_q <= 1'b0;
      miss_q       <= 1'b0;
      missCnt_q    <= '0;
      fault_q      <= 1'b0;
      busy_q       <= 1'b0;
      phaseCnt_q   <= '0;
      periodCnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      hb_q         <= hb_d;
      lvl_q        <= lvl_d;
      pulseStart_q <= pulseStart_d;
      miss_q       <= miss_d;
      missCnt_q    <= missCnt_d;
      fault_q      <= fault_d;
      busy_q       <= busy_d;
      phaseCnt_q   <= phaseCnt_d;
      periodCnt_q  <= periodCnt_d;
    end
  end

  assign o_hb          = hb_q;
  assign o_pulse_start = pulseStart_q;
  assign o_miss        = miss_q;
  assign o_miss_cnt    = missCnt_q;
  assign o_fault       = fault_q;
  assign o_busy        = busy_q;

endmodule
